hfast_arb2: RTL and testbench

- Two-client arbiter sharing one wide HFAST off-chip DRAM port (e.g. two Kiwi bondout ports onto a single 256-bit membank).
- Each client sees a complete HFAST port: opreq/oprdy command handshake, rwbar, addr, lanes, wdata, ack, rdata.
- Round-robin per-beat grant; an in-order tag FIFO steers each memory ack and rdata back to the client that issued the op.
- Back-to-back beats pass at full rate while the tag FIFO has room.

---
 rtl/hfast_arb2.sv | 135 +++++++++++++
 tb/tb_hfast_arb2.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hfast_arb2.sv
// hfast_arb2: two-client round-robin arbiter onto one HFAST memory port.
// Commands pass combinationally from the winning client to the memory;
// an in-order tag FIFO records which client issued each accepted op so
// that every memory ack (and its rdata) is steered back to its owner.
module hfast_arb2 #(
  parameter int DW     = 256,
  parameter int AW     = 22,
  parameter int TDEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  // client 0
  input  logic              c0_opreq,
  output logic              c0_oprdy,
  input  logic              c0_rwbar,
  input  logic [AW-1:0]     c0_addr,
  input  logic [DW/8-1:0]   c0_lanes,
  input  logic [DW-1:0]     c0_wdata,
  output logic              c0_ack,
  output logic [DW-1:0]     c0_rdata,
  // client 1
  input  logic              c1_opreq,
  output logic              c1_oprdy,
  input  logic              c1_rwbar,
  input  logic [AW-1:0]     c1_addr,
  input  logic [DW/8-1:0]   c1_lanes,
  input  logic [DW-1:0]     c1_wdata,
  output logic              c1_ack,
  output logic [DW-1:0]     c1_rdata,
  // shared memory port
  output logic              m_opreq,
  input  logic              m_oprdy,
  output logic              m_rwbar,
  output logic [AW-1:0]     m_addr,
  output logic [DW/8-1:0]   m_lanes,
  output logic [DW-1:0]     m_wdata,
  input  logic              m_ack,
  input  logic [DW-1:0]     m_rdata,
  output logic              err
);

  localparam int PW = $clog2(TDEPTH);
  localparam int CW = PW + 1;

  // Control state: round-robin pointer and tag FIFO bookkeeping.
  logic          rr;
  logic [CW-1:0] count;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  // Tag storage only needs the issuing client id: rdata is broadcast to
  // both clients and qualified by ack, so the op direction is not needed
  // to route a completion.
  logic          tag_id [TDEPTH];

  logic full;
  logic empty;
  logic elig0;
  logic elig1;
  logic win_vld;
  logic win_id;
  logic accept;
  logic pop;
  logic head_id;

  assign full  = (count == CW'(TDEPTH));
  assign empty = (count == '0);

  // A full FIFO blocks every grant, even when an ack frees a slot this
  // cycle. Gating with reset keeps all handshakes low while reset is held.
  assign elig0 = reset & c0_opreq & ~full;
  assign elig1 = reset & c1_opreq & ~full;

  // Winner select: a lone eligible client wins, a tie goes to rr.
  always_comb begin
    win_vld = elig0 | elig1;
    win_id  = (elig0 & elig1) ? rr : elig1;
  end

  // Command mux; with no winner win_id is 0 so client 0 drives the bus.
  always_comb begin
    m_opreq = win_vld;
    m_rwbar = win_id ? c1_rwbar : c0_rwbar;
    m_addr  = win_id ? c1_addr  : c0_addr;
    m_lanes = win_id ? c1_lanes : c0_lanes;
    m_wdata = win_id ? c1_wdata : c0_wdata;
  end

  assign accept   = win_vld & m_oprdy;
  assign c0_oprdy = accept & ~win_id;
  assign c1_oprdy = accept &  win_id;

  // Completion routing: an ack with no outstanding tag is dropped.
  assign head_id  = tag_id[rptr];
  assign pop      = reset & m_ack & ~empty;
  assign c0_ack   = pop & ~head_id;
  assign c1_ack   = pop &  head_id;
  assign c0_rdata = m_rdata;
  assign c1_rdata = m_rdata;

  // Pointer, occupancy, round-robin and sticky error updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr    <= 1'b0;
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        wptr <= wptr + PW'(1);
        rr   <= ~win_id;
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (m_ack && empty) begin
        err <= 1'b1;
      end
    end
  end

  // Tag payload write; stale entries are never read because count gates pops.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_id[wptr] <= win_id;
    end
  end

endmodule

// File: tb/tb_hfast_arb2.sv
// Directed bench for hfast_arb2: drives both clients and plays the memory,
// keeping a queue of expected completions (issuing client and address).
module tb_hfast_arb2;

  localparam int DW = 256;
  localparam int AW = 22;
  localparam int LW = DW / 8;
  localparam int TDEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          c0_opreq, c0_oprdy, c0_rwbar, c0_ack;
  logic [AW-1:0] c0_addr;
  logic [LW-1:0] c0_lanes;
  logic [DW-1:0] c0_wdata, c0_rdata;
  logic          c1_opreq, c1_oprdy, c1_rwbar, c1_ack;
  logic [AW-1:0] c1_addr;
  logic [LW-1:0] c1_lanes;
  logic [DW-1:0] c1_wdata, c1_rdata;
  logic          m_opreq, m_oprdy, m_rwbar, m_ack;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_lanes;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          err;

  hfast_arb2 #(.DW(DW), .AW(AW), .TDEPTH(TDEPTH)) dut (
    .clk(clk), .reset(reset),
    .c0_opreq(c0_opreq), .c0_oprdy(c0_oprdy), .c0_rwbar(c0_rwbar),
    .c0_addr(c0_addr), .c0_lanes(c0_lanes), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_rdata(c0_rdata),
    .c1_opreq(c1_opreq), .c1_oprdy(c1_oprdy), .c1_rwbar(c1_rwbar),
    .c1_addr(c1_addr), .c1_lanes(c1_lanes), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_rdata(c1_rdata),
    .m_opreq(m_opreq), .m_oprdy(m_oprdy), .m_rwbar(m_rwbar),
    .m_addr(m_addr), .m_lanes(m_lanes), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            id;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_err = 1'b0;
  logic exp_err_pend = 1'b0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{{10'h2A5, a}}};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle. mack: 0 = no ack, 1 = ack, 2 = ack if anything is outstanding.
  // ew: expected winner (0/1) or -1 when no request should reach memory.
  task automatic do_cycle(input bit q0, input logic [AW-1:0] a0,
                          input bit q1, input logic [AW-1:0] a1,
                          input bit mrdy, input int mack, input int ew);
    bit   do_ack;
    exp_t h;
    logic [AW-1:0] wa;
    @(posedge clk); #1;
    exp_err  = exp_err_pend;
    c0_opreq = q0; c0_addr = a0; c0_wdata = ~pat(a0);
    c1_opreq = q1; c1_addr = a1; c1_wdata = ~pat(a1);
    m_oprdy  = mrdy;
    do_ack   = (mack == 2) ? (exp_q.size() > 0) : (mack == 1);
    m_ack    = do_ack;
    m_rdata  = (exp_q.size() > 0) ? pat(exp_q[0].addr) : '0;
    #3;
    wa = (ew == 1) ? a1 : a0;
    chk1("err", err, exp_err);
    chk1("m_opreq", m_opreq, ew >= 0);
    if (ew >= 0) begin
      chkd("m_addr", DW'(m_addr), DW'(wa));
      chk1("m_rwbar", m_rwbar, (ew == 1) ? c1_rwbar : c0_rwbar);
      chkd("m_lanes", DW'(m_lanes), DW'((ew == 1) ? c1_lanes : c0_lanes));
      chkd("m_wdata", m_wdata, ~pat(wa));
    end
    chk1("c0_oprdy", c0_oprdy, (ew == 0) && mrdy);
    chk1("c1_oprdy", c1_oprdy, (ew == 1) && mrdy);
    if (do_ack && exp_q.size() > 0) begin
      h = exp_q.pop_front();
      chk1("c0_ack", c0_ack, h.id == 1'b0);
      chk1("c1_ack", c1_ack, h.id == 1'b1);
      chkd("rdata", h.id ? c1_rdata : c0_rdata, pat(h.addr));
    end else begin
      chk1("c0_ack_idle", c0_ack, 1'b0);
      chk1("c1_ack_idle", c1_ack, 1'b0);
      if (do_ack) exp_err_pend = 1'b1;
    end
    if (ew >= 0 && mrdy) begin
      h.id = (ew == 1);
      h.addr = wa;
      exp_q.push_back(h);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) do_cycle(0, '0, 0, '0, 1, 2, -1);
    chk1("drain_done", exp_q.size() == 0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    c0_opreq = 1'b1; c1_opreq = 1'b1; m_oprdy = 1'b1; m_ack = 1'b0;
    #1;
    chk1("rst_c0_oprdy", c0_oprdy, 1'b0);
    chk1("rst_c1_oprdy", c1_oprdy, 1'b0);
    chk1("rst_m_opreq", m_opreq, 1'b0);
    chk1("rst_err", err, 1'b0);
    exp_q.delete();
    exp_err = 1'b0; exp_err_pend = 1'b0;
    c0_opreq = 1'b0; c1_opreq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    c0_opreq = 0; c0_rwbar = 1; c0_addr = '0; c0_lanes = '1; c0_wdata = '0;
    c1_opreq = 0; c1_rwbar = 1; c1_addr = '0; c1_lanes = '1; c1_wdata = '0;
    m_oprdy = 0; m_ack = 0; m_rdata = '0;
    #2;
    do_reset();

    // Single client: three back-to-back reads, memory acks one cycle later.
    do_cycle(1, 22'd0, 0, '0, 1, 2, 0);
    do_cycle(1, 22'd1, 0, '0, 1, 2, 0);
    do_cycle(1, 22'd2, 0, '0, 1, 2, 0);
    drain();

    // Contention from reset: grants alternate starting with client 0.
    do_reset();
    c1_rwbar = 1'b0; c1_lanes = 32'hF0F0_F0F0;
    do_cycle(1, 22'd10, 1, 22'd20, 1, 2, 0);
    do_cycle(1, 22'd11, 1, 22'd20, 1, 2, 1);
    do_cycle(1, 22'd11, 1, 22'd21, 1, 2, 0);
    do_cycle(1, 22'd12, 1, 22'd21, 1, 2, 1);
    drain();

    // FIFO full: memory withholds acks while client 0 streams writes.
    c0_rwbar = 1'b0; c0_lanes = 32'h0000_000F;
    do_cycle(1, 22'd100, 0, '0, 1, 0, 0);
    do_cycle(1, 22'd101, 0, '0, 1, 0, 0);
    do_cycle(1, 22'd102, 0, '0, 1, 0, 0);
    do_cycle(1, 22'd103, 0, '0, 1, 0, 0);
    do_cycle(1, 22'd104, 0, '0, 1, 0, -1);
    do_cycle(1, 22'd104, 0, '0, 1, 1, -1);
    do_cycle(1, 22'd104, 0, '0, 1, 0, 0);
    do_cycle(1, 22'd105, 0, '0, 1, 0, -1);
    drain();

    // Memory stall with rr pointing at client 1: no accepts, then rr order.
    c0_rwbar = 1'b1; c0_lanes = '1;
    for (int i = 0; i < 5; i++) do_cycle(1, 22'd30, 1, 22'd40, 0, 0, 1);
    do_cycle(1, 22'd30, 1, 22'd40, 1, 2, 1);
    do_cycle(1, 22'd30, 1, 22'd41, 1, 2, 0);
    do_cycle(1, 22'd31, 1, 22'd41, 1, 2, 1);
    drain();

    // Spurious ack with nothing outstanding: sticky error, nothing forwarded.
    do_cycle(0, '0, 0, '0, 1, 1, -1);
    do_cycle(0, '0, 0, '0, 1, 0, -1);
    do_cycle(0, '0, 0, '0, 1, 0, -1);

    // Asynchronous reset with three reads outstanding.
    do_cycle(1, 22'd50, 0, '0, 1, 0, 0);
    do_cycle(1, 22'd51, 0, '0, 1, 0, 0);
    do_cycle(1, 22'd52, 0, '0, 1, 0, 0);
    @(posedge clk); #1;
    c0_opreq = 1'b1; c0_addr = 22'd53; m_ack = 1'b1; m_rdata = pat(22'd50);
    #1;
    chk1("pre_rst_c0_ack", c0_ack, 1'b1);
    chk1("pre_rst_err", err, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk1("arst_c0_oprdy", c0_oprdy, 1'b0);
    chk1("arst_c0_ack", c0_ack, 1'b0);
    chk1("arst_m_opreq", m_opreq, 1'b0);
    chk1("arst_err", err, 1'b0);
    exp_q.delete();
    exp_err = 1'b0; exp_err_pend = 1'b0;
    m_ack = 1'b0; c0_opreq = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    // rr back at client 0, FIFO empty: one op, its ack, then a stray ack.
    do_cycle(1, 22'd60, 1, 22'd70, 1, 0, 0);
    do_cycle(0, '0, 0, '0, 1, 2, -1);
    do_cycle(0, '0, 0, '0, 1, 1, -1);
    do_cycle(0, '0, 0, '0, 1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
